// File: rtl/shift_reg_mode.sv
// Multi-mode shift register: hold, shift down, shift up or parallel load, with a
// selectable tap, full parallel view, synchronous clear and a saturating fill counter.
module shift_reg_mode #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4,
  localparam int TSW  = (DEPTH > 2) ? $clog2(DEPTH) : 1,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   en,
  input  logic [1:0]             mode,
  input  logic [WIDTH-1:0]       datain,
  input  logic [WIDTH*DEPTH-1:0] load_data,
  input  logic [TSW-1:0]         tap_sel,
  output logic [WIDTH-1:0]       dataout,
  output logic [WIDTH-1:0]       upout,
  output logic [WIDTH-1:0]       tapout,
  output logic [WIDTH*DEPTH-1:0] parout,
  output logic [CW-1:0]          fill_cnt,
  output logic                   full
);

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_DOWN = 2'b01;
  localparam logic [1:0] MODE_UP   = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  localparam logic [CW-1:0] FILL_MAX = CW'(DEPTH);

  logic [WIDTH-1:0] r_stage [DEPTH];
  logic [CW-1:0]    r_fill;
  logic [CW-1:0]    w_fill_inc;
  logic [WIDTH-1:0] w_tap;

  assign w_fill_inc = (r_fill == FILL_MAX) ? r_fill : r_fill + CW'(1);

  // NOTE: every stage reads its neighbour's old value in the same edge, so all
  // state updates use non-blocking assignments; blocking ones would ripple data
  // through several stages in one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
      r_fill <= '0;
    end else if (clear) begin
      for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
      r_fill <= '0;
    end else if (en) begin
      case (mode)
        MODE_DOWN: begin
          for (int i = 0; i < DEPTH - 1; i++) r_stage[i] <= r_stage[i+1];
          r_stage[DEPTH-1] <= datain;
          r_fill           <= w_fill_inc;
        end
        MODE_UP: begin
          for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
          r_stage[0] <= datain;
          r_fill     <= w_fill_inc;
        end
        MODE_LOAD: begin
          for (int i = 0; i < DEPTH; i++) r_stage[i] <= load_data[i*WIDTH +: WIDTH];
          r_fill <= FILL_MAX;
        end
        default: ;  // MODE_HOLD
      endcase
    end
  end

  // NOTE: w_tap is given a default before the search loop so that no tap_sel
  // value leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_tap = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (int'(tap_sel) == i) w_tap = r_stage[i];
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_par
    assign parout[g*WIDTH +: WIDTH] = r_stage[g];
  end

  assign dataout  = r_stage[0];
  assign upout    = r_stage[DEPTH-1];
  assign tapout   = w_tap;
  assign fill_cnt = r_fill;
  assign full     = (r_fill == FILL_MAX);

endmodule

// File: tb/tb_shift_reg_mode.sv
// Directed bench for shift_reg_mode: default 2x4 instance plus an 8x16 instance.
module tb_shift_reg_mode;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  // Instance A: WIDTH=2, DEPTH=4
  logic       a_clear, a_en;
  logic [1:0] a_mode, a_datain, a_tap_sel, a_dataout, a_upout, a_tapout;
  logic [7:0] a_load_data, a_parout;
  logic [2:0] a_fill_cnt;
  logic       a_full;

  shift_reg_mode #(.WIDTH(2), .DEPTH(4)) u_a (
    .clk(clk), .reset(reset), .clear(a_clear), .en(a_en), .mode(a_mode),
    .datain(a_datain), .load_data(a_load_data), .tap_sel(a_tap_sel),
    .dataout(a_dataout), .upout(a_upout), .tapout(a_tapout), .parout(a_parout),
    .fill_cnt(a_fill_cnt), .full(a_full)
  );

  // Instance B: WIDTH=8, DEPTH=16
  logic         b_clear, b_en;
  logic [1:0]   b_mode;
  logic [7:0]   b_datain, b_dataout, b_upout, b_tapout;
  logic [127:0] b_load_data, b_parout;
  logic [3:0]   b_tap_sel;
  logic [4:0]   b_fill_cnt;
  logic         b_full;

  shift_reg_mode #(.WIDTH(8), .DEPTH(16)) u_b (
    .clk(clk), .reset(reset), .clear(b_clear), .en(b_en), .mode(b_mode),
    .datain(b_datain), .load_data(b_load_data), .tap_sel(b_tap_sel),
    .dataout(b_dataout), .upout(b_upout), .tapout(b_tapout), .parout(b_parout),
    .fill_cnt(b_fill_cnt), .full(b_full)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_a(input string tag, input logic [7:0] par, input logic [2:0] fill);
    check({tag, ".parout"}, 128'(a_parout), 128'(par));
    check({tag, ".fill"}, 128'(a_fill_cnt), 128'(fill));
    check({tag, ".full"}, 128'(a_full), 128'(fill == 3'd4));
  endtask

  initial begin
    reset = 1'b1;
    a_clear = 0; a_en = 0; a_mode = 2'b00; a_datain = '0; a_load_data = '0; a_tap_sel = '0;
    b_clear = 0; b_en = 0; b_mode = 2'b00; b_datain = '0; b_load_data = '0; b_tap_sel = '0;
    #12;
    check_a("reset", 8'h00, 3'd0);
    check("reset.dataout", 128'(a_dataout), 128'(0));
    check("reset.upout", 128'(a_upout), 128'(0));
    check("reset.b_parout", b_parout, 128'(0));
    tick();
    reset = 1'b0;

    // Down-shift fill: datain 1,2,3,0
    a_en = 1; a_mode = 2'b01;
    a_datain = 2'd1; tick(); check_a("down1", 8'h40, 3'd1); check("down1.dataout", 128'(a_dataout), 128'(0));
    a_datain = 2'd2; tick(); check_a("down2", 8'h90, 3'd2); check("down2.dataout", 128'(a_dataout), 128'(0));
    a_datain = 2'd3; tick(); check_a("down3", 8'hE4, 3'd3); check("down3.dataout", 128'(a_dataout), 128'(0));
    a_datain = 2'd0; tick(); check_a("down4", 8'h39, 3'd4); check("down4.dataout", 128'(a_dataout), 128'(1));
    check("down4.upout", 128'(a_upout), 128'(0));

    // Stall for 3 cycles
    a_en = 0; a_datain = 2'd2;
    for (int i = 0; i < 3; i++) begin
      tick(); check_a("stall", 8'h39, 3'd4);
    end

    // 6 more shifts of 1: fill saturates
    a_en = 1; a_datain = 2'd1;
    for (int i = 0; i < 6; i++) begin
      tick(); check("sat.fill", 128'(a_fill_cnt), 128'(4));
    end
    check_a("sat.end", 8'h55, 3'd4);

    // Mode 00 with en=1 holds
    a_mode = 2'b00; a_datain = 2'd3; tick(); check_a("hold", 8'h55, 3'd4);

    // Clear beats en and shift
    a_clear = 1; a_mode = 2'b01; a_datain = 2'd3; tick(); check_a("clear", 8'h00, 3'd0);
    a_clear = 0;

    // Parallel load E4
    a_mode = 2'b11; a_load_data = 8'hE4; tick();
    check_a("load", 8'hE4, 3'd4);
    check("load.dataout", 128'(a_dataout), 128'(0));
    check("load.upout", 128'(a_upout), 128'(3));

    // Tap sweep (no clock edge needed)
    a_en = 0;
    for (int i = 0; i < 4; i++) begin
      a_tap_sel = 2'(i); #1;
      check("tap", 128'(a_tapout), 128'(i));
    end

    // Up-shift
    a_en = 1; a_mode = 2'b10; a_datain = 2'd1; tick(); check_a("up1", 8'h91, 3'd4);
    a_datain = 2'd2; tick(); check_a("up2", 8'h46, 3'd4); check("up2.upout", 128'(a_upout), 128'(1));

    // Async reset between edges
    #2 reset = 1'b1; #1;
    check_a("areset", 8'h00, 3'd0);
    check("areset.dataout", 128'(a_dataout), 128'(0));
    check("areset.upout", 128'(a_upout), 128'(0));
    check("areset.tapout", 128'(a_tapout), 128'(0));
    #2 reset = 1'b0;

    // First edge after release shifts; direction change keeps counting
    a_mode = 2'b10; a_datain = 2'd3; tick(); check_a("post_rst", 8'h03, 3'd1);
    a_mode = 2'b01; a_datain = 2'd2; tick(); check_a("dir_chg", 8'h80, 3'd2);

    // WIDTH=8, DEPTH=16: incrementing byte stream
    b_en = 1; b_mode = 2'b01; b_tap_sel = 4'd5;
    for (int n = 1; n <= 20; n++) begin
      b_datain = 8'(n);
      tick();
      check("b.dataout", 128'(b_dataout), 128'((n >= 16) ? n - 15 : 0));
      check("b.tapout", 128'(b_tapout), 128'((n >= 11) ? n - 10 : 0));
      check("b.upout", 128'(b_upout), 128'(n));
      check("b.full", 128'(b_full), 128'(n >= 16));
      check("b.fill", 128'(b_fill_cnt), 128'((n >= 16) ? 16 : n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
